// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and constants for the bit-serial adder.
//   state_t   : controller state encoding (IDLE, RUN, DONE), 2 bits.
//   MIN_WIDTH : smallest supported operand width.
//   MAX_WIDTH : largest supported operand width.
package serial_adder_pkg;

    localparam int MIN_WIDTH = 2;
    localparam int MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : serial_adder_pkg

// File: rtl/serial_adder_fa_bit.sv
// fa_bit: purely combinational one-bit full adder.
//   a, b, cin : addend bits and carry-in
//   s         : sum bit
//   cout      : carry-out
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule : fa_bit

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder. Computes {cout,sum} = a + b + cin
// one bit per clock, LSB first, through a single fa_bit cell and a carry
// flip-flop. The result appears WIDTH cycles after start is accepted.
//
// Ports:
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   start      : request, sampled only while idle
//   a, b, cin  : operands and carry-in, captured on the accepting edge
//   busy       : high while bits are being processed
//   done       : one-cycle strobe; sum/cout are valid while it is high
//   sum, cout  : registered result, held until the next completion
//   ovf        : signed overflow, captured with sum
//                (present only when SERIAL_ADDER_OVF_EN is defined)
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,output logic             ovf
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    if ((WIDTH < MIN_WIDTH) || (WIDTH > MAX_WIDTH)) begin : g_bad_width
        $error("serial_adder: WIDTH out of supported range");
    end

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh;
    // Only WIDTH-1 partial-sum bits need storage: the final bit goes
    // straight from the cell into sum on the last step.
    logic [WIDTH-2:0] sum_sh;
    logic [WIDTH-1:0] sum_cat;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_s, fa_cout;
    logic             last_bit;
    logic             accept, step;

    fa_bit u_fa (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign sum_cat  = {fa_s, sum_sh};
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // NOTE: every output of this block is defaulted first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        step      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (last_bit) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the shift registers, carry and counter are reset along with the
    // results so an aborted operation leaves no stale state behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf    <= 1'b0;
`endif
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
        end else if (step) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= sum_cat[WIDTH-1:1];
            carry  <= fa_cout;
            cnt    <= cnt + CNT_W'(1);
            if (last_bit) begin
                sum  <= sum_cat;
                cout <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                // On the MSB step, carry holds the carry into the MSB.
                ovf  <= carry ^ fa_cout;
`endif
            end
        end
    end

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder (WIDTH=8). Stimulus
// pushes the hand-computed result and the cycle it must appear on; a
// monitor pops and compares whenever done is high.
module tb_serial_adder;

    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        int               cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a, b;
    logic             cin;
    logic             busy, done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    exp_t sb[$];

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
       ,.ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every done strobe against the oldest expectation.
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", done, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sum", sum, e.sum);
                check("cout", cout, e.cout);
                check("done_cycle", cyc, e.cyc);
`ifdef SERIAL_ADDER_OVF_EN
                check("ovf", ovf, e.ovf);
`endif
            end
        end
    end

    // Drive one start pulse and record the expected result; the done strobe
    // is due WIDTH edges after the accepting edge.
    task automatic issue(input logic [WIDTH-1:0] ia, input logic [WIDTH-1:0] ib, input logic ic,
                         input logic [WIDTH-1:0] es, input logic ec, input logic eo);
        @(negedge clk);
        a     = ia;
        b     = ib;
        cin   = ic;
        start = 1'b1;
        sb.push_back('{sum: es, cout: ec, ovf: eo, cyc: cyc + 1 + WIDTH});
        @(negedge clk);
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        check("busy_after_accept", busy, 1'b1);
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (sb.size() == 0) return;
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            failures++;
            checks++;
            $display("FAIL drain_timeout: %0d results still pending after %0d cycles", sb.size(), budget);
            sb.delete();
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_sum", sum, 8'h00);
        check("reset_cout", cout, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
        check("reset_ovf", ovf, 1'b0);
`endif
        rst_n = 1'b1;

        // Basic add with signed overflow.
        issue(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1);
        wait_drain(30);
        @(negedge clk);
        check("busy_idle_after_done", busy, 1'b0);

        // Carry ripples through every bit.
        issue(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        wait_drain(30);

        // All ones with carry-in, then all zeros.
        issue(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
        wait_drain(30);
        issue(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        wait_drain(30);

        // start re-pulsed mid-RUN must be ignored.
        issue(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        a     = 8'hFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a     = '0;
        wait_drain(30);
        repeat (4) @(negedge clk);

        // Reset three cycles into RUN aborts the operation.
        issue(8'h80, 8'h01, 1'b0, 8'h81, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_sum", sum, 8'h00);
        check("abort_cout", cout, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_done", done, 1'b0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        issue(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
        wait_drain(30);

        // start held high: one acceptance every WIDTH+2 cycles.
        @(negedge clk);
        a     = 8'h7F;
        b     = 8'h01;
        cin   = 1'b0;
        start = 1'b1;
        sb.push_back('{sum: 8'h80, cout: 1'b0, ovf: 1'b1, cyc: cyc + 1 + WIDTH});
        repeat (WIDTH + 2) @(negedge clk);
        a   = 8'h80;
        b   = 8'h80;
        cin = 1'b0;
        sb.push_back('{sum: 8'h00, cout: 1'b1, ovf: 1'b1, cyc: cyc + 1 + WIDTH});
        repeat (WIDTH + 2) @(negedge clk);
        a   = 8'hAA;
        b   = 8'h55;
        cin = 1'b1;
        sb.push_back('{sum: 8'h00, cout: 1'b1, ovf: 1'b0, cyc: cyc + 1 + WIDTH});
        @(negedge clk);
        start = 1'b0;
        wait_drain(40);
        repeat (4) @(negedge clk);

        check("scoreboard_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_serial_adder
